// File: rtl/fcn2_vector_driver.sv
// fcn2_vector_driver
// Walks a range of 4-bit vectors {A,B,C,D} into the fcn2 block.
// After each vector has settled, it samples X/Y and checks them against a built-in golden model.
// It counts mismatches and keeps the first failing vector and its observed {X,Y}.
// SETTLE_CYCLES must stay within 1..15 so that the settle counter fits in 4 bits.
module fcn2_vector_driver #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] first_vec,
  input  logic [3:0] last_vec,
  input  logic       X,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic [3:0] vec_idx,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec,
  output logic [1:0] fail_xy,
  output logic       pass
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] last_q;
  logic [3:0] settle_cnt;
  logic       w4, exp_x, exp_y;
  logic       mismatch;

  // The drive lines are the current vector index.
  // They therefore hold their value in IDLE/DONE and fall to zero on reset.
  assign {A, B, C, D} = vec_idx;

  assign busy = (state == APPLY) || (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);

  // Golden fcn2 model that is evaluated on the vector currently being driven.
  always_comb begin
    w4       = vec_idx[3] | ~(vec_idx[2] | vec_idx[1]);
    exp_x    = ~(vec_idx[0] | vec_idx[2]) ^ w4;
    exp_y    = vec_idx[0] & w4;
    mismatch = (state == CHECK) && ({X, Y} != {exp_x, exp_y});
  end

  // State register; reset aborts a run at once without producing a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // A run ends after the last vector, or at the first mismatch when STOP_ON_FAIL is set.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   state_next = SETTLE;
      SETTLE:  if (settle_cnt == 4'd0) state_next = CHECK;
      CHECK: begin
        if ((vec_idx == last_q) || (STOP_ON_FAIL && mismatch)) state_next = DONE;
        else                                                   state_next = APPLY;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath.
  // It latches the range on start, times the settle window, scores each check and advances the vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= 4'd0;
      settle_cnt <= 4'd0;
      vec_idx    <= 4'd0;
      err_count  <= 5'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 4'd0;
      fail_xy    <= 2'b00;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_q     <= last_vec;
            vec_idx    <= first_vec;
            err_count  <= 5'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 4'd0;
            fail_xy    <= 2'b00;
            pass       <= 1'b0;
          end
        end
        APPLY: begin
          settle_cnt <= 4'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec_idx;
              fail_xy    <= {X, Y};
            end
          end
          if (state_next == APPLY) vec_idx <= vec_idx + 4'd1;
        end
        DONE: begin
          pass <= (err_count == 5'd0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcn2_vector_driver.sv
// Testbench for fcn2_vector_driver.
// Two instances are used, one with STOP_ON_FAIL=0 and one with STOP_ON_FAIL=1.
// Each instance is connected to a reference fcn2 whose Y output can be stuck at 0 to inject a fault.
module tb_fcn2_vector_driver;

  localparam int SETTLE = 2;
  localparam int PER_VEC = SETTLE + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic [3:0] first_vec, last_vec;
  logic       fault;

  logic       a1, b1, c1, d1, x1, y1, busy1, done1, fail_valid1, pass1;
  logic [3:0] vec_idx1, fail_vec1;
  logic [4:0] err_count1;
  logic [1:0] fail_xy1, xy1_good;

  logic       a2, b2, c2, d2, x2, y2, busy2, done2, fail_valid2, pass2;
  logic [3:0] vec_idx2, fail_vec2;
  logic [4:0] err_count2;
  logic [1:0] fail_xy2, xy2_good;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         run_cycles;
  logic [3:0] seq [0:15];
  int         seq_n;
  bit         use2;
  logic       done_s, busy_s;
  logic [3:0] vec_s;

  always #5 clk = ~clk;

  // Reference fcn2 behaviour used as the device under stimulus.
  function automatic logic [1:0] fcn2(input logic a, input logic b, input logic c, input logic d);
    logic w4;
    w4 = a | ~(b | c);
    return {~(d | b) ^ w4, d & w4};
  endfunction

  assign xy1_good = fcn2(a1, b1, c1, d1);
  assign x1       = xy1_good[1];
  assign y1       = xy1_good[0] & ~fault;
  assign xy2_good = fcn2(a2, b2, c2, d2);
  assign x2       = xy2_good[1];
  assign y2       = xy2_good[0] & ~fault;

  assign done_s = use2 ? done2 : done1;
  assign busy_s = use2 ? busy2 : busy1;
  assign vec_s  = use2 ? vec_idx2 : vec_idx1;

  fcn2_vector_driver #(.SETTLE_CYCLES(SETTLE), .STOP_ON_FAIL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .first_vec(first_vec), .last_vec(last_vec),
    .X(x1), .Y(y1), .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
    .vec_idx(vec_idx1), .err_count(err_count1), .fail_valid(fail_valid1),
    .fail_vec(fail_vec1), .fail_xy(fail_xy1), .pass(pass1)
  );

  fcn2_vector_driver #(.SETTLE_CYCLES(SETTLE), .STOP_ON_FAIL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .first_vec(first_vec), .last_vec(last_vec),
    .X(x2), .Y(y2), .A(a2), .B(b2), .C(c2), .D(d2), .busy(busy2), .done(done2),
    .vec_idx(vec_idx2), .err_count(err_count2), .fail_valid(fail_valid2),
    .fail_vec(fail_vec2), .fail_xy(fail_xy2), .pass(pass2)
  );

  // Counts one comparison and reports it when the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart(input bit sel, input logic [3:0] f, input logic [3:0] l);
    @(negedge clk);
    use2      = sel;
    first_vec = f;
    last_vec  = l;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Runs one vector range on the selected instance and returns its length through run_cycles.
  // The length is counted in negedges after the start-sampling edge, up to and including the done cycle.
  // The vector driven in each APPLY cycle is recorded in seq.
  // With extra_start set, a second start carrying a different range is pulsed in the middle of the run.
  task automatic applyStimulus(input bit sel, input logic [3:0] f, input logic [3:0] l, input bit extra_start);
    pulseStart(sel, f, l);
    run_cycles = 1;
    seq_n      = 0;
    while (!done_s && run_cycles < 200) begin
      if (((run_cycles - 1) % PER_VEC) == 0 && seq_n < 16) begin
        seq[seq_n] = vec_s;
        seq_n++;
      end
      if (extra_start && run_cycles == 6) begin
        first_vec = 4'd8;
        last_vec  = 4'd15;
        if (sel) start2 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
      @(negedge clk);
      run_cycles++;
    end
    start1 = 1'b0;
    start2 = 1'b0;
    checkOutput("done_seen", {31'd0, done_s}, 32'd1);
    @(negedge clk);
  endtask

  logic [3:0] dir_vec [4] = '{4'd0, 4'd15, 4'd3, 4'd5};
  logic [1:0] dir_xy  [4] = '{2'b00, 2'b11, 2'b00, 2'b00};

  initial begin
    int  wait_n;
    bit  saw_done;

    rst       = 1'b1;
    start1    = 1'b0;
    start2    = 1'b0;
    first_vec = 4'd0;
    last_vec  = 4'd0;
    fault     = 1'b0;
    use2      = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_vec_idx", {28'd0, vec_idx1}, 32'd0);
    checkOutput("rst_abcd", {28'd0, a1, b1, c1, d1}, 32'd0);
    checkOutput("rst_flags", {28'd0, busy1, done1, fail_valid1, pass1}, 32'd0);
    checkOutput("rst_err_count", {27'd0, err_count1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean walk over the full range.
    applyStimulus(1'b0, 4'd0, 4'd15, 1'b0);
    checkOutput("full_cycles", run_cycles, 32'd65);
    checkOutput("full_err_count", {27'd0, err_count1}, 32'd0);
    checkOutput("full_pass", {31'd0, pass1}, 32'd1);
    checkOutput("full_fail_valid", {31'd0, fail_valid1}, 32'd0);
    checkOutput("full_busy_idle", {31'd0, busy1}, 32'd0);

    // Single-vector directed runs.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, dir_vec[i], dir_vec[i], 1'b0);
      checkOutput($sformatf("dir%0d_cycles", i), run_cycles, 32'd5);
      checkOutput($sformatf("dir%0d_xy", i), {30'd0, x1, y1}, {30'd0, dir_xy[i]});
      checkOutput($sformatf("dir%0d_pass", i), {31'd0, pass1}, 32'd1);
    end

    // Inject a fault by holding Y at 0, then walk the full range.
    fault = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd15, 1'b0);
    checkOutput("fault_cycles", run_cycles, 32'd65);
    checkOutput("fault_err_count", {27'd0, err_count1}, 32'd5);
    checkOutput("fault_fail_valid", {31'd0, fail_valid1}, 32'd1);
    checkOutput("fault_fail_vec", {28'd0, fail_vec1}, 32'd1);
    checkOutput("fault_fail_xy", {30'd0, fail_xy1}, 32'b10);
    checkOutput("fault_pass", {31'd0, pass1}, 32'd0);

    // Same fault on the instance that stops at the first failure.
    applyStimulus(1'b1, 4'd0, 4'd15, 1'b0);
    checkOutput("stop_cycles", run_cycles, 32'd9);
    checkOutput("stop_err_count", {27'd0, err_count2}, 32'd1);
    checkOutput("stop_fail_vec", {28'd0, fail_vec2}, 32'd1);
    checkOutput("stop_fail_xy", {30'd0, fail_xy2}, 32'b10);
    checkOutput("stop_pass", {31'd0, pass2}, 32'd0);
    fault = 1'b0;

    // A range that wraps from 15 back to 0.
    applyStimulus(1'b0, 4'd14, 4'd1, 1'b0);
    checkOutput("wrap_cycles", run_cycles, 32'd17);
    checkOutput("wrap_count", seq_n, 32'd4);
    checkOutput("wrap_seq0", {28'd0, seq[0]}, 32'd14);
    checkOutput("wrap_seq1", {28'd0, seq[1]}, 32'd15);
    checkOutput("wrap_seq2", {28'd0, seq[2]}, 32'd0);
    checkOutput("wrap_seq3", {28'd0, seq[3]}, 32'd1);
    checkOutput("wrap_pass", {31'd0, pass1}, 32'd1);

    // A second start during a run must be ignored.
    applyStimulus(1'b0, 4'd0, 4'd3, 1'b1);
    checkOutput("busy_start_cycles", run_cycles, 32'd17);
    checkOutput("busy_start_seq1", {28'd0, seq[1]}, 32'd1);
    checkOutput("busy_start_final_vec", {28'd0, vec_idx1}, 32'd3);
    checkOutput("busy_start_pass", {31'd0, pass1}, 32'd1);
    checkOutput("busy_start_not_busy", {31'd0, busy1}, 32'd0);

    // Assert reset during SETTLE of vector 5.
    pulseStart(1'b0, 4'd0, 4'd15);
    wait_n = 0;
    while (!(busy1 && vec_idx1 == 4'd5) && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput("midrst_reached_vec5", {28'd0, vec_idx1}, 32'd5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_vec_idx", {28'd0, vec_idx1}, 32'd0);
    checkOutput("midrst_abcd", {28'd0, a1, b1, c1, d1}, 32'd0);
    checkOutput("midrst_flags", {28'd0, busy1, done1, fail_valid1, pass1}, 32'd0);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done1) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done1) saw_done = 1'b1;
    end
    checkOutput("midrst_no_done", {31'd0, saw_done}, 32'd0);
    checkOutput("midrst_idle", {31'd0, busy1}, 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd15, 1'b0);
    checkOutput("after_rst_cycles", run_cycles, 32'd65);
    checkOutput("after_rst_pass", {31'd0, pass1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fcn2_vector_driver.md
Name: fcn2_vector_driver

Overview:
Upstream stimulus-and-check stage for the fcn2 combinational block. It walks a programmable range of 4-bit input vectors {A,B,C,D} into fcn2 and waits a fixed settle time. It then samples fcn2's X/Y outputs and compares them against an internal golden model, counting mismatches and recording the first failing vector. It replaces hand-written per-vector stimulus and gives a single pass/fail result per run.

Parameters:
SETTLE_CYCLES, 2, number of cycles between driving a vector and sampling X/Y (legal range 1..15)
STOP_ON_FAIL, 0, 1 = end the run at the first mismatch; 0 = walk the full range

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle run request; ignored unless IDLE
first_vec  input  4  first vector {A,B,C,D}; sampled with start
last_vec  input  4  last vector; sampled with start
X  input  1  fcn2 output X
Y  input  1  fcn2 output Y
A  output  1  drive to fcn2 A (first_vec/vec_idx bit 3)
B  output  1  drive to fcn2 B (bit 2)
C  output  1  drive to fcn2 C (bit 1)
D  output  1  drive to fcn2 D (bit 0)
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of run
vec_idx  output  4  vector currently driven
err_count  output  5  mismatches in the current or last run
fail_valid  output  1  at least one mismatch recorded
fail_vec  output  4  first failing vector
fail_xy  output  2  {X,Y} observed at the first failure
pass  output  1  high in IDLE after a run with err_count==0

Behaviour:
- Golden model: w4 = A | ~(B|C); exp_X = ~(D|B) ^ w4; exp_Y = D & w4.
- Reset (asynchronous): state=IDLE. A,B,C,D,vec_idx,err_count,fail_vec,fail_xy=0. busy,done,fail_valid,pass=0. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE with start=1: latch first/last, vec_idx<=first_vec, clear err_count/fail_valid/fail_xy/fail_vec/pass, go to APPLY. Start in any other state is ignored.
- APPLY (1 cycle): {A,B,C,D} reflect vec_idx. Settle counter <= SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: decrement each cycle; at 0 go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle): compare {X,Y} to {exp_X,exp_Y} for vec_idx.
  - On mismatch: err_count+1. If fail_valid==0, capture fail_vec=vec_idx and fail_xy={X,Y}, and set fail_valid.
  - Next state is DONE if vec_idx==last, or if (STOP_ON_FAIL and a mismatch occurred this cycle). Otherwise vec_idx<=vec_idx+1 (mod 16) and go to APPLY.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0). Go to IDLE.
- Range and wrap: if first_vec>last_vec the walk wraps 15->0. Vector count = ((last-first) mod 16)+1, maximum 16, so err_count (5 bits) never overflows. first==last runs exactly one vector.
- Cycles per vector = SETTLE_CYCLES+2. Run length from the start-sampling edge to the done pulse = N*(SETTLE_CYCLES+2)+1 cycles.
- A,B,C,D hold their last value in IDLE/DONE. Results hold until the next accepted start.

Test Plan:
- Full-range clean run: rst, start with first=0, last=15, golden fcn2 attached -> 16 vectors, done after 65 cycles (SETTLE=2), err_count=0, pass=1, fail_valid=0.
- Directed vectors: ranges 0000..0000, 1111..1111, 0011..0011, 0101..0101 -> sampled {X,Y} = 00, 11, 00, 00 respectively; pass=1 for each.
- Fault injection: fcn2 Y output forced to 0, range 0..15 -> err_count=5 (vectors 1,9,11,13,15), fail_vec=0001, fail_xy=10, pass=0. Same with STOP_ON_FAIL=1 -> err_count=1, done after the second vector.
- Wrap-around: first=14, last=1 -> vec_idx sequence 14,15,0,1, exactly 4 CHECK cycles, then done.
- Start while busy: second start mid-run -> ignored; first_vec/last_vec unchanged, run length unchanged.
- Reset mid-run: assert rst during SETTLE of vector 5 -> all outputs 0 immediately, no done pulse; a new start afterwards completes normally.
